// File: rtl/filter_kernel_sequencer.sv
// filter_kernel_sequencer: issues one kernel row plus the matching window pixel row per cycle to a MAC array; optional win_cnt output via FILTER_SEQ_WIN_CNT_EN
module filter_kernel_sequencer #(
   parameter int ROWS                    = 3,
   parameter int TAPS                    = 3,
   parameter int PIXEL_WIDTH             = 24,
   parameter int KERNEL_MEMORY_BUS_WIDTH = 96
) (
   input  logic                                  clk,
   input  logic                                  nreset,
   input  logic                                  kernel_wr_en,
   input  logic [1:0]                            kernel_wr_addr,
   input  logic [KERNEL_MEMORY_BUS_WIDTH-1:0]    kernel_wr_data,
   output logic                                  kernel_wr_err,
   input  logic                                  win_valid,
   output logic                                  win_ready,
   input  logic [ROWS*TAPS*PIXEL_WIDTH-1:0]      win_data,
   output logic [KERNEL_MEMORY_BUS_WIDTH-1:0]    kernel_input_vec,
   output logic [TAPS*PIXEL_WIDTH-1:0]           pixel_input_vec,
   output logic                                  en,
`ifdef FILTER_SEQ_WIN_CNT_EN
   output logic [31:0]                           win_cnt,
`endif
   output logic                                  last_kernel
);
   localparam int RW = TAPS * PIXEL_WIDTH;
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t                             r_state, w_next;
   logic [1:0]                         r_row_cnt, w_row;
   logic                               w_last, w_hs, w_launch, w_wr_ok;
   logic [KERNEL_MEMORY_BUS_WIDTH-1:0] r_kernel [ROWS];
   logic [RW-1:0]                      r_win [ROWS];
   assign w_last    = r_row_cnt == 2'(ROWS - 1);
   assign win_ready = (r_state == IDLE) | ((r_state == ISSUE) & w_last);
   assign w_hs      = win_valid & win_ready;
   assign w_wr_ok   = kernel_wr_en & (r_state == IDLE) & (32'(kernel_wr_addr) < ROWS);
   // next state and which row (if any) launches at the coming edge
   always_comb begin
      w_next   = w_hs ? ISSUE : (w_last ? IDLE : r_state);
      w_launch = w_hs | ((r_state == ISSUE) & ~w_last);
      w_row    = w_hs ? 2'd0 : r_row_cnt + 2'd1;
   end
   // state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   // row launch, window capture, kernel storage; row 0 reads the pre-write kernel
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_row_cnt        <= '0;
         en               <= 1'b0;
         last_kernel      <= 1'b0;
         kernel_input_vec <= '0;
         pixel_input_vec  <= '0;
         kernel_wr_err    <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            r_kernel[r] <= '0;
            r_win[r]    <= '0;
         end
      end else begin
         en            <= w_launch;
         last_kernel   <= w_launch & (w_row == 2'(ROWS - 1));
         kernel_wr_err <= kernel_wr_en & ~w_wr_ok;
         if (w_launch) begin
            r_row_cnt        <= w_row;
            kernel_input_vec <= r_kernel[w_row];
            pixel_input_vec  <= w_hs ? win_data[RW-1:0] : r_win[w_row];
         end
         if (w_hs) for (int r = 0; r < ROWS; r++) r_win[r] <= win_data[r*RW +: RW];
         if (w_wr_ok) r_kernel[kernel_wr_addr] <= kernel_wr_data;
      end
   end
`ifdef FILTER_SEQ_WIN_CNT_EN
   logic [31:0] r_win_cnt;
   assign win_cnt = r_win_cnt;
   // accepted-window counter, wraps naturally
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)   r_win_cnt <= '0;
      else if (w_hs) r_win_cnt <= r_win_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_filter_kernel_sequencer.sv
// tb_filter_kernel_sequencer: scoreboard bench for filter_kernel_sequencer (ROWS=3)
module tb_filter_kernel_sequencer;
   localparam int ROWS = 3;
   typedef struct {
      logic [95:0] k;
      logic [71:0] p;
      logic        l;
   } exp_t;
   logic          clk = 1'b0, nreset = 1'b0, kernel_wr_en = 1'b0, win_valid = 1'b0;
   logic [1:0]    kernel_wr_addr = '0;
   logic [95:0]   kernel_wr_data = '0;
   logic [215:0]  win_data = '0;
   logic          kernel_wr_err, win_ready, en, last_kernel;
   logic [95:0]   kernel_input_vec;
   logic [71:0]   pixel_input_vec;
`ifdef FILTER_SEQ_WIN_CNT_EN
   logic [31:0]   win_cnt;
`endif
   int            total = 0, bad = 0, run = 0, max_run = 0, hs = 0;
   exp_t          q[$];
   exp_t          e;
   logic [95:0]   km [ROWS];

   filter_kernel_sequencer #(.ROWS(ROWS)) dut (
      .clk(clk), .nreset(nreset),
      .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr),
      .kernel_wr_data(kernel_wr_data), .kernel_wr_err(kernel_wr_err),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .kernel_input_vec(kernel_input_vec), .pixel_input_vec(pixel_input_vec),
      .en(en),
`ifdef FILTER_SEQ_WIN_CNT_EN
      .win_cnt(win_cnt),
`endif
      .last_kernel(last_kernel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_k(input logic [1:0] a, input logic [95:0] d, input logic drop);
      kernel_wr_en   = 1'b1;
      kernel_wr_addr = a;
      kernel_wr_data = d;
      cyc();
      kernel_wr_en = 1'b0;
      chk("wr_err", 96'(kernel_wr_err), 96'(drop));
      if (!drop) km[a] = d;
   endtask

   task automatic send(input logic [71:0] p0, input logic [71:0] p1, input logic [71:0] p2, input bit keep);
      int n = 0;
      win_valid = 1'b1;
      win_data  = {p2, p1, p0};
      while (!win_ready && n < 20) begin
         cyc();
         n++;
      end
      chk("ready_wait", 96'(win_ready), 96'd1);
      q.push_back('{km[0], p0, 1'b0});
      q.push_back('{km[1], p1, 1'b0});
      q.push_back('{km[2], p2, 1'b1});
      hs++;
      cyc();
      if (!keep) win_valid = 1'b0;
   endtask

   // monitor: every en cycle must match the oldest expected row
   always @(negedge clk) begin
      if (nreset) begin
         if (en) begin
            run++;
            if (run > max_run) max_run = run;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_en: en=1 kvec=%h pvec=%h with no row expected", kernel_input_vec, pixel_input_vec);
            end else begin
               e = q.pop_front();
               chk("row_kernel", kernel_input_vec, e.k);
               chk("row_pixel", 96'(pixel_input_vec), 96'(e.p));
               chk("row_last", 96'(last_kernel), 96'(e.l));
            end
         end else begin
            run = 0;
            chk("idle_last", 96'(last_kernel), 96'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < ROWS; r++) km[r] = '0;
      #12;
      chk("rst_en", 96'(en), 96'd0);
      chk("rst_last", 96'(last_kernel), 96'd0);
      chk("rst_kvec", kernel_input_vec, 96'd0);
      chk("rst_pvec", 96'(pixel_input_vec), 96'd0);
      chk("rst_err", 96'(kernel_wr_err), 96'd0);
      chk("rst_ready", 96'(win_ready), 96'd1);
      nreset = 1'b1;
      cyc();
      // single window, uniform kernel and pixels
      for (int r = 0; r < ROWS; r++) wr_k(2'(r), {3{32'h00000400}}, 1'b0);
      send({3{24'h102030}}, {3{24'h102030}}, {3{24'h102030}}, 1'b0);
      chk("busy_ready_c1", 96'(win_ready), 96'd0);
      cyc();
      chk("busy_ready_c2", 96'(win_ready), 96'd0);
      cyc();
      chk("busy_ready_c3", 96'(win_ready), 96'd1);
      cyc();
      cyc();
      chk("hold_en", 96'(en), 96'd0);
      chk("hold_kvec", kernel_input_vec, {3{32'h00000400}});
      chk("hold_pvec", 96'(pixel_input_vec), 96'({3{24'h102030}}));
      // distinct kernels, back-to-back windows A and B
      wr_k(2'd0, 96'h00000011_00000012_00000013, 1'b0);
      wr_k(2'd1, 96'h00000021_00000022_00000023, 1'b0);
      wr_k(2'd2, 96'h00000031_00000032_00000033, 1'b0);
      max_run = 0;
      send(72'h0A0001_0A0002_0A0003, 72'h0A0101_0A0102_0A0103, 72'h0A0201_0A0202_0A0203, 1'b1);
      send(72'h0B0001_0B0002_0B0003, 72'h0B0101_0B0102_0B0103, 72'h0B0201_0B0202_0B0203, 1'b0);
      repeat (6) cyc();
      chk("b2b_run", 96'(max_run), 96'd6);
      // write dropped while issuing; kernel row 1 must stay intact
      send(72'h0C0001_0C0002_0C0003, 72'h0C0101_0C0102_0C0103, 72'h0C0201_0C0202_0C0203, 1'b0);
      cyc();
      wr_k(2'd1, {3{32'hDEADBEEF}}, 1'b1);
      cyc();
      chk("err_pulse_end", 96'(kernel_wr_err), 96'd0);
      repeat (3) cyc();
      wr_k(2'd3, {3{32'h0000CAFE}}, 1'b1);
      cyc();
      chk("err_pulse_end2", 96'(kernel_wr_err), 96'd0);
      send(72'h0D0001_0D0002_0D0003, 72'h0D0101_0D0102_0D0103, 72'h0D0201_0D0202_0D0203, 1'b0);
      repeat (5) cyc();
      // reset in the middle of a window
      send(72'h0E0001_0E0002_0E0003, 72'h0E0101_0E0102_0E0103, 72'h0E0201_0E0202_0E0203, 1'b0);
      cyc();
      nreset = 1'b0;
      q.delete();
      hs = 0;
      for (int r = 0; r < ROWS; r++) km[r] = '0;
      #1;
      chk("mid_rst_en", 96'(en), 96'd0);
      chk("mid_rst_last", 96'(last_kernel), 96'd0);
      chk("mid_rst_kvec", kernel_input_vec, 96'd0);
      chk("mid_rst_pvec", 96'(pixel_input_vec), 96'd0);
      #2;
      nreset = 1'b1;
      cyc();
      chk("post_rst_ready", 96'(win_ready), 96'd1);
      repeat (4) cyc();
      chk("post_rst_en", 96'(en), 96'd0);
      // kernel write on the handshake edge affects only later windows
      wr_k(2'd0, 96'h00000041_00000042_00000043, 1'b0);
      wr_k(2'd1, 96'h00000051_00000052_00000053, 1'b0);
      wr_k(2'd2, 96'h00000061_00000062_00000063, 1'b0);
      kernel_wr_en   = 1'b1;
      kernel_wr_addr = 2'd0;
      kernel_wr_data = {3{32'h00000800}};
      send(72'h0F0001_0F0002_0F0003, 72'h0F0101_0F0102_0F0103, 72'h0F0201_0F0202_0F0203, 1'b0);
      kernel_wr_en = 1'b0;
      chk("same_edge_err", 96'(kernel_wr_err), 96'd0);
      km[0] = {3{32'h00000800}};
      repeat (4) cyc();
      send(72'h100001_100002_100003, 72'h100101_100102_100103, 72'h100201_100202_100203, 1'b0);
      repeat (5) cyc();
`ifdef FILTER_SEQ_WIN_CNT_EN
      chk("win_cnt_count", 96'(win_cnt), 96'(hs));
      force dut.r_win_cnt = 32'hFFFFFFFF;
      cyc();
      release dut.r_win_cnt;
      chk("win_cnt_preload", 96'(win_cnt), 96'hFFFFFFFF);
      send(72'h110001_110002_110003, 72'h110101_110102_110103, 72'h110201_110202_110203, 1'b0);
      chk("win_cnt_wrap", 96'(win_cnt), 96'd0);
      repeat (5) cyc();
`endif
      chk("queue_drained", 96'(q.size()), 96'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
